// File: rtl/sram_bank_arbiter_pkg.sv
// Shared parameters for the on-chip buffer arbiter.
// Holds the multi_sram geometry (bank count and widths), the default
// requester count and bank-index width, and the requester-id names.
// It also provides a constant clog2 helper used to size the priority
// pointers.
package sram_bank_arbiter_pkg;

    localparam int NUM_SRAMS      = 6;
    localparam int MAX_ADDR_WIDTH = 8;
    localparam int MAX_DATA_WIDTH = 16;
    localparam int SRAM_WIDTH_O   = 16;

    localparam int NUM_REQ_DEF    = 3;
    localparam int BANK_W_DEF     = 3;

    localparam int REQ_DMA        = 0;
    localparam int REQ_CONV       = 1;
    localparam int REQ_POST       = 2;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/sram_bank_arbiter_rr_arbiter.sv
// Round-robin arbiter for one bank.
// The search starts at i_ptr and wraps modulo N. The first requester found
// with its request bit set wins.
//   i_req  : request vector (valid and targeting this bank)
//   i_ptr  : highest-priority requester id
//   o_gnt  : one-hot grant
//   o_any  : some requester was granted
//   o_id   : binary id of the granted requester (0 when o_any=0)
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic          o_any,
    output logic [PW-1:0] o_id
);

    always_comb begin : p_search
        int w_idx;
        o_gnt = '0;
        o_any = 1'b0;
        o_id  = '0;
        w_idx = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_any        = 1'b1;
                o_id         = PW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Per-bank round-robin arbiter in front of multi_sram.
// Each of NUM_REQ requesters issues single-beat reads or writes to one
// bank. Requests to different banks are granted in the same cycle.
// Read data comes back exactly one cycle after the grant, on the granted
// requester's rsp lane.
//   clk, rst     : clock, asynchronous active-low reset
//   req_valid    : per-requester request valid
//   req_ready    : per-requester grant (combinational)
//   req_bank     : per-requester target bank
//   req_we       : per-requester write enable
//   req_addr     : per-requester word address
//   req_wdata    : per-requester write data
//   rsp_valid    : per-requester read-data-valid pulse
//   rsp_data     : per-requester read data
//   sram_en      : multi_sram enables
//   sram_we      : multi_sram write enables
//   sram_addr    : multi_sram addresses
//   sram_wdata   : multi_sram write data
//   sram_rdata   : multi_sram read data
module sram_bank_arbiter
    import sram_bank_arbiter_pkg::*;
#(
    parameter int NUM_REQ           = NUM_REQ_DEF,
    parameter int BANK_W            = BANK_W_DEF,
    parameter bit BAD_BANK_IS_ERROR = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*BANK_W-1:0]           req_bank,
    input  logic [NUM_REQ-1:0]                  req_we,
    input  logic [NUM_REQ*MAX_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*MAX_DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [NUM_REQ*SRAM_WIDTH_O-1:0]     rsp_data,
    output logic [NUM_SRAMS-1:0]                sram_en,
    output logic [NUM_SRAMS-1:0]                sram_we,
    output logic [NUM_SRAMS*MAX_ADDR_WIDTH-1:0] sram_addr,
    output logic [NUM_SRAMS*MAX_DATA_WIDTH-1:0] sram_wdata,
    input  logic [NUM_SRAMS*SRAM_WIDTH_O-1:0]   sram_rdata
);

    localparam int ID_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
    localparam int AW   = MAX_ADDR_WIDTH;
    localparam int DW   = MAX_DATA_WIDTH;
    localparam int OW   = SRAM_WIDTH_O;

    logic [NUM_REQ-1:0]   w_bank_req [NUM_SRAMS];
    logic [NUM_REQ-1:0]   w_gnt      [NUM_SRAMS];
    logic [NUM_SRAMS-1:0] w_any;
    logic [ID_W-1:0]      w_id       [NUM_SRAMS];

    logic [ID_W-1:0]      r_ptr      [NUM_SRAMS];
    logic [NUM_SRAMS-1:0] r_rd_pend;
    logic [ID_W-1:0]      r_rd_owner [NUM_SRAMS];

    // Gating with rst keeps every grant, and so every SRAM strobe, low
    // while reset is held. Bank indices >= NUM_SRAMS match no arbiter,
    // so those requests are never granted.
    always_comb begin
        for (int b = 0; b < NUM_SRAMS; b++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                w_bank_req[b][r] = rst && req_valid[r] &&
                                   (req_bank[r*BANK_W +: BANK_W] == BANK_W'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_SRAMS; b++) begin : g_bank
        rr_arbiter #(
            .N  (NUM_REQ),
            .PW (ID_W)
        ) u_rr (
            .i_req (w_bank_req[b]),
            .i_ptr (r_ptr[b]),
            .o_gnt (w_gnt[b]),
            .o_any (w_any[b]),
            .o_id  (w_id[b])
        );
    end

    always_comb begin
        req_ready  = '0;
        sram_en    = '0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        for (int b = 0; b < NUM_SRAMS; b++) begin
            req_ready = req_ready | w_gnt[b];
            if (w_any[b]) begin
                sram_en[b]              = 1'b1;
                sram_we[b]              = req_we[w_id[b]];
                sram_addr[b*AW +: AW]   = req_addr[int'(w_id[b])*AW +: AW];
                sram_wdata[b*DW +: DW]  = req_wdata[int'(w_id[b])*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < NUM_SRAMS; b++) begin
                r_ptr[b]      <= '0;
                r_rd_owner[b] <= '0;
            end
            r_rd_pend <= '0;
        end else begin
            for (int b = 0; b < NUM_SRAMS; b++) begin
                if (w_any[b]) begin
                    r_ptr[b] <= ID_W'((int'(w_id[b]) + 1) % NUM_REQ);
                end
                r_rd_pend[b] <= w_any[b] && !req_we[w_id[b]];
                if (w_any[b] && !req_we[w_id[b]]) begin
                    r_rd_owner[b] <= w_id[b];
                end
            end
        end
    end

    // A requester has at most one read in flight, so no two banks ever
    // return data to the same lane in the same cycle.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int b = 0; b < NUM_SRAMS; b++) begin
            if (r_rd_pend[b]) begin
                rsp_valid[r_rd_owner[b]]                 = 1'b1;
                rsp_data[int'(r_rd_owner[b])*OW +: OW]   = sram_rdata[b*OW +: OW];
            end
        end
    end

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_bank_chk
        a_bank_in_range: assert property (@(posedge clk) disable iff (!rst)
            !(req_valid[r] &&
              ({1'b0, req_bank[r*BANK_W +: BANK_W]} >= (BANK_W+1)'(NUM_SRAMS))))
        else begin
            if (BAD_BANK_IS_ERROR)
                $error("requester %0d targets nonexistent bank %0d", r,
                       req_bank[r*BANK_W +: BANK_W]);
            else
                $warning("requester %0d targets nonexistent bank %0d", r,
                         req_bank[r*BANK_W +: BANK_W]);
        end
    end

endmodule

// File: tb/tb_sram_bank_arbiter.sv
module tb_sram_bank_arbiter;
    import sram_bank_arbiter_pkg::*;

    localparam int NR = 3;
    localparam int BW = 3;
    localparam int AW = MAX_ADDR_WIDTH;
    localparam int DW = MAX_DATA_WIDTH;
    localparam int OW = SRAM_WIDTH_O;
    localparam int NB = NUM_SRAMS;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*BW-1:0]   req_bank;
    logic [NR-1:0]      req_we;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdata;
    logic [NR-1:0]      rsp_valid;
    logic [NR*OW-1:0]   rsp_data;
    logic [NB-1:0]      sram_en;
    logic [NB-1:0]      sram_we;
    logic [NB*AW-1:0]   sram_addr;
    logic [NB*DW-1:0]   sram_wdata;
    logic [NB*OW-1:0]   sram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_bank_arbiter #(
        .NUM_REQ           (NR),
        .BANK_W            (BW),
        .BAD_BANK_IS_ERROR (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_bank   (req_bank),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Stand-in for multi_sram: 1-cycle synchronous read; contents reload to
    // (bank << 12) | addr whenever reset is held.
    logic [DW-1:0] mem [NB][256];
    always @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < NB; b++)
                for (int a = 0; a < 256; a++)
                    mem[b][a] <= DW'((b << 12) | a);
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (sram_en[b]) begin
                    if (sram_we[b])
                        mem[b][sram_addr[b*AW +: AW]] <= sram_wdata[b*DW +: DW];
                    else
                        sram_rdata[b*OW +: OW] <= mem[b][sram_addr[b*AW +: AW]];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int r, input logic v, input int bank,
                           input logic we, input int addr, input int wd);
        req_valid[r]          = v;
        req_bank[r*BW +: BW]  = BW'(bank);
        req_we[r]             = we;
        req_addr[r*AW +: AW]  = AW'(addr);
        req_wdata[r*DW +: DW] = DW'(wd);
    endtask

    task automatic clear_all();
        for (int r = 0; r < NR; r++) set_req(r, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int r = 0; r < NR; r++) set_req(r, 1'b1, 0, 1'b0, 9, 0);
        #1;
        n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL reset_ready got %b want 000", req_ready); end
        n_cmp++; if (sram_en !== 6'b0) begin n_bad++; $display("FAIL reset_en got %b want 000000", sram_en); end
        n_cmp++; if (rsp_valid !== 3'b000) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 000", rsp_valid); end
        n_cmp++; if (rsp_data !== '0) begin n_bad++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        tick();
        n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL reset_hold_ready got %b want 000", req_ready); end
        rst = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL reset_first_grant got %b want 001", req_ready); end
        n_cmp++; if (sram_en !== 6'b000001) begin n_bad++; $display("FAIL reset_first_en got %b want 000001", sram_en); end
        tick();
        clear_all();
        #1;
        n_cmp++; if (rsp_valid !== 3'b001) begin n_bad++; $display("FAIL reset_first_rsp got %b want 001", rsp_valid); end
        n_cmp++; if (rsp_data[0 +: OW] !== 16'h0009) begin n_bad++; $display("FAIL reset_first_data got %h want 0009", rsp_data[0 +: OW]); end
        tick();
    endtask

    task automatic test_parallel();
        set_req(0, 1'b1, 0, 1'b0, 5, 0);
        set_req(1, 1'b1, 3, 1'b1, 7, 'h5A);
        #1;
        n_cmp++; if (req_ready !== 3'b011) begin n_bad++; $display("FAIL par_ready got %b want 011", req_ready); end
        n_cmp++; if (sram_en !== 6'b001001) begin n_bad++; $display("FAIL par_en got %b want 001001", sram_en); end
        n_cmp++; if (sram_we !== 6'b001000) begin n_bad++; $display("FAIL par_we got %b want 001000", sram_we); end
        n_cmp++; if (sram_addr[3*AW +: AW] !== 8'h07) begin n_bad++; $display("FAIL par_addr3 got %h want 07", sram_addr[3*AW +: AW]); end
        n_cmp++; if (sram_wdata[3*DW +: DW] !== 16'h005A) begin n_bad++; $display("FAIL par_wdata3 got %h want 005a", sram_wdata[3*DW +: DW]); end
        n_cmp++; if (sram_addr[0 +: AW] !== 8'h05) begin n_bad++; $display("FAIL par_addr0 got %h want 05", sram_addr[0 +: AW]); end
        tick();
        clear_all();
        #1;
        n_cmp++; if (rsp_valid !== 3'b001) begin n_bad++; $display("FAIL par_rsp_valid got %b want 001", rsp_valid); end
        n_cmp++; if (rsp_data[0 +: OW] !== 16'h0005) begin n_bad++; $display("FAIL par_rsp_data got %h want 0005", rsp_data[0 +: OW]); end
        tick();
    endtask

    task automatic test_contention();
        logic [NR-1:0] exp_g;
        logic [NR-1:0] prev_g;
        int prev_r;
        prev_g = '0;
        prev_r = 0;
        for (int r = 0; r < NR; r++) set_req(r, 1'b1, 2, 1'b0, r + 1, 0);
        #1;
        for (int i = 0; i < 6; i++) begin
            exp_g = NR'(1) << (i % 3);
            n_cmp++; if (req_ready !== exp_g) begin n_bad++; $display("FAIL cont_grant[%0d] got %b want %b", i, req_ready, exp_g); end
            if (i > 0) begin
                n_cmp++; if (rsp_valid !== prev_g) begin n_bad++; $display("FAIL cont_rsp_valid[%0d] got %b want %b", i, rsp_valid, prev_g); end
                n_cmp++; if (rsp_data[prev_r*OW +: OW] !== 16'(16'h2001 + prev_r)) begin n_bad++; $display("FAIL cont_rsp_data[%0d] got %h want %h", i, rsp_data[prev_r*OW +: OW], 16'(16'h2001 + prev_r)); end
            end
            prev_g = exp_g;
            prev_r = i % 3;
            tick();
        end
        clear_all();
        #1;
        n_cmp++; if (rsp_valid !== 3'b100) begin n_bad++; $display("FAIL cont_last_rsp got %b want 100", rsp_valid); end
        n_cmp++; if (rsp_data[2*OW +: OW] !== 16'h2003) begin n_bad++; $display("FAIL cont_last_data got %h want 2003", rsp_data[2*OW +: OW]); end
        tick();
    endtask

    task automatic test_back_to_back();
        set_req(0, 1'b1, 1, 1'b0, 'h20, 0);
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL b2b_ready0 got %b want 001", req_ready); end
        for (int i = 1; i < 3; i++) begin
            tick();
            set_req(0, 1'b1, 1, 1'b0, 'h20 + i, 0);
            #1;
            n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL b2b_ready[%0d] got %b want 001", i, req_ready); end
            n_cmp++; if (rsp_valid !== 3'b001) begin n_bad++; $display("FAIL b2b_rsp[%0d] got %b want 001", i, rsp_valid); end
            n_cmp++; if (rsp_data[0 +: OW] !== 16'(16'h101F + i)) begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, rsp_data[0 +: OW], 16'(16'h101F + i)); end
        end
        tick();
        clear_all();
        #1;
        n_cmp++; if (rsp_data[0 +: OW] !== 16'h1022) begin n_bad++; $display("FAIL b2b_last_data got %h want 1022", rsp_data[0 +: OW]); end
        tick();
        n_cmp++; if (rsp_valid !== 3'b000) begin n_bad++; $display("FAIL b2b_no_extra got %b want 000", rsp_valid); end
    endtask

    task automatic test_write_read();
        set_req(1, 1'b1, 1, 1'b1, 'h10, 'h3C);
        #1;
        n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL wr_ready got %b want 010", req_ready); end
        n_cmp++; if (sram_we !== 6'b000010) begin n_bad++; $display("FAIL wr_we got %b want 000010", sram_we); end
        tick();
        set_req(1, 1'b1, 1, 1'b0, 'h10, 0);
        #1;
        n_cmp++; if (rsp_valid !== 3'b000) begin n_bad++; $display("FAIL wr_no_rsp got %b want 000", rsp_valid); end
        tick();
        clear_all();
        #1;
        n_cmp++; if (rsp_valid !== 3'b010) begin n_bad++; $display("FAIL rd_rsp_valid got %b want 010", rsp_valid); end
        n_cmp++; if (rsp_data[1*OW +: OW] !== 16'h003C) begin n_bad++; $display("FAIL rd_rsp_data got %h want 003c", rsp_data[1*OW +: OW]); end
        tick();
    endtask

    task automatic test_rw_same_bank();
        set_req(0, 1'b1, 4, 1'b1, 'h33, 'h1234);
        set_req(2, 1'b1, 4, 1'b0, 'h33, 0);
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL rw_win got %b want 001", req_ready); end
        tick();
        set_req(0, 1'b0, 4, 1'b1, 'h33, 'h1234);
        #1;
        n_cmp++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL rw_loser got %b want 100", req_ready); end
        n_cmp++; if (sram_we[4] !== 1'b0) begin n_bad++; $display("FAIL rw_loser_we got %b want 0", sram_we[4]); end
        tick();
        clear_all();
        #1;
        n_cmp++; if (rsp_valid !== 3'b100) begin n_bad++; $display("FAIL rw_rsp got %b want 100", rsp_valid); end
        n_cmp++; if (rsp_data[2*OW +: OW] !== 16'h1234) begin n_bad++; $display("FAIL rw_data got %h want 1234", rsp_data[2*OW +: OW]); end
        tick();
    endtask

    task automatic test_invalid_bank();
        set_req(2, 1'b1, 7, 1'b0, 1, 0);
        set_req(1, 1'b1, 6, 1'b0, 1, 0);
        #1;
        n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL bad_ready got %b want 000", req_ready); end
        n_cmp++; if (sram_en !== 6'b0) begin n_bad++; $display("FAIL bad_en got %b want 000000", sram_en); end
        tick();
        tick();
        n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL bad_ready_hold got %b want 000", req_ready); end
        n_cmp++; if (rsp_valid !== 3'b000) begin n_bad++; $display("FAIL bad_rsp got %b want 000", rsp_valid); end
        clear_all();
        tick();
    endtask

    task automatic test_mid_read_reset();
        set_req(0, 1'b1, 5, 1'b0, 1, 0);
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL mrr_grant got %b want 001", req_ready); end
        tick();
        rst = 1'b0;
        clear_all();
        #1;
        n_cmp++; if (rsp_valid !== 3'b000) begin n_bad++; $display("FAIL mrr_rsp got %b want 000", rsp_valid); end
        n_cmp++; if (rsp_data !== '0) begin n_bad++; $display("FAIL mrr_data got %h want 0", rsp_data); end
        tick();
        n_cmp++; if (rsp_valid !== 3'b000) begin n_bad++; $display("FAIL mrr_rsp_hold got %b want 000", rsp_valid); end
        rst = 1'b1;
        // Bank 0's pointer was 1 before reset; a cleared pointer favours r0.
        set_req(0, 1'b1, 0, 1'b0, 2, 0);
        set_req(1, 1'b1, 0, 1'b0, 3, 0);
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL mrr_ptr_cleared got %b want 001", req_ready); end
        n_cmp++; if (rsp_valid !== 3'b000) begin n_bad++; $display("FAIL mrr_no_late_rsp got %b want 000", rsp_valid); end
        clear_all();
        tick();
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0;
        req_bank  = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        tick();
        test_reset();
        test_parallel();
        test_contention();
        test_back_to_back();
        test_write_read();
        test_rw_same_bank();
        test_invalid_bank();
        test_mid_read_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got stuck want finish");
        $fatal(1, "timeout");
    end

endmodule
